pipe_ex_sink: RTL and testbench

- Receive-side buffer at the output of the 4-stage arithmetic pipeline (F = ((A+B)+(C-D))*D).
- That pipeline emits one result per clk, has no backpressure, and marks results with a valid strobe.
- This block captures every valid result into a first-word-fall-through FIFO and hands results to a downstream consumer over a valid/ready handshake.
- Results that arrive while the FIFO is full are dropped and accounted for, never silently lost.

---
 rtl/pipe_ex_pkg.sv | 19 +
 rtl/pipe_ex_sink_if.sv | 40 ++++
 rtl/sync_fifo_fwft.sv | 65 ++++++
 rtl/pipe_ex_sink.sv | 63 ++++++
 tb/tb_pipe_ex_sink.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/pipe_ex_pkg.sv
// Shared constants and helpers for the arithmetic pipeline receive side.
package pipe_ex_pkg;

  // Width of the pipeline result F = ((A+B)+(C-D))*D.
  localparam int RES_W = 10;

  // Width of the saturating dropped-result counter.
  localparam int DROP_W = 8;

  // Saturation value of the dropped-result counter.
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  // Index width for a power-of-two FIFO of the given depth. The pointers
  // themselves carry one extra wrap bit on top of this.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipe_ex_sink_if.sv
// Result handshake bundle between the pipeline, this sink and the consumer.
//
// Handshake rules:
//   in_valid/in_data  : pushed by the pipeline, one result per clk while
//                       in_valid=1. There is no backpressure on this side.
//   out_valid/out_ready: a transfer happens on a rising clk edge where both
//                       are 1. out_valid does not depend on out_ready, and
//                       out_data is stable for as long as out_valid=1 and
//                       no transfer has taken place.
interface pipe_ex_sink_if
  import pipe_ex_pkg::*;
#(
  parameter int N = RES_W
);

  logic         in_valid;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  // Producer/consumer side: feeds results in, takes results out.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  // Buffer side: accepts results and offers the head entry.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is read
// combinationally from the registered array, so data pushed at edge k is
// visible right after edge k. Pointers carry a wrap bit so full and empty
// are told apart without a separate counter register.
module sync_fifo_fwft
  import pipe_ex_pkg::*;
#(
  parameter  int W     = RES_W,
  parameter  int DEPTH = 4,            // power of two, at least 2
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop never happens on an empty FIFO. A push into a full FIFO is only
  // taken when a pop frees the head slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer state: each advances by one on its own operation, wrapping
  // naturally at 2^(AW+1).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write. Contents are left alone by reset; a push coinciding with
  // reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Status derived from the registered pointers only.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // Head entry, fall-through from the array on the registered read pointer.
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pipe_ex_sink.sv
// Receive-side buffer behind the 4-stage arithmetic pipeline. Every valid
// result goes into a FWFT FIFO; results arriving while the FIFO is full and
// not being drained are dropped and counted so the loss is always visible.
module pipe_ex_sink
  import pipe_ex_pkg::*;
#(
  parameter  int N     = RES_W,
  parameter  int DEPTH = 4,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ex_sink_if.slave     bus,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic         pop;
  logic         drop;
  logic [N-1:0] head;

  // The consumer only transfers when an entry is actually offered.
  assign pop = bus.out_valid & bus.out_ready;

  // A result is lost only when there is no room and no simultaneous pop.
  assign drop = bus.in_valid & full & ~pop;

  sync_fifo_fwft #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;

  // Drop accounting: sticky overflow flag plus a counter that holds at its
  // maximum. Reset wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipe_ex_sink.sv
// Self-checking bench for pipe_ex_sink with a queue-based reference model.
module tb_pipe_ex_sink;
  import pipe_ex_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = ptr_w(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ex_sink_if #(.N(RES_W)) bus ();

  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  pipe_ex_sink #(
    .N     (RES_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  int               m_drops;
  logic             m_ovf;
  int               n_vec;
  int               n_err;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Check the state left by the previous edge, then predict the next edge.
  // Inputs were set right after the previous edge; sampling is on negedge.
  task automatic cycle();
    int   m_cnt;
    logic m_pop;
    @(negedge clk);
    m_cnt = exp_q.size();
    check_eq("count",     32'(count),         m_cnt);
    check_eq("full",      32'(full),          32'(m_cnt == DEPTH));
    check_eq("empty",     32'(empty),         32'(m_cnt == 0));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_cnt != 0));
    check_eq("overflow",  32'(overflow),      32'(m_ovf));
    check_eq("drop_cnt",  32'(drop_cnt),      m_drops);
    if (rst) begin
      exp_q.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
    end else begin
      m_pop = (m_cnt != 0) && bus.out_ready;
      if (m_pop) check_eq("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      if (bus.in_valid) begin
        if (m_cnt < DEPTH || m_pop) begin
          exp_q.push_back(bus.in_data);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [RES_W-1:0] d,
                       input logic rdy, input logic rs);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    rst           = rs;
    cycle();
  endtask

  logic [RES_W-1:0] seq [8];

  initial begin
    seq = '{10'd75, 10'd66, 10'd112, 10'd62, 10'd0, 10'd66, 10'd49, 10'd166};
    n_vec = 0;
    n_err = 0;
    m_drops = 0;
    m_ovf = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: streaming with the consumer always ready
    for (int i = 0; i < 8; i++) drive(1'b1, seq[i], 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // 2: fill, one drop, drain in order
    for (int i = 0; i < 5; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // 3: full with simultaneous push and pop
    for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 1'b0, 1'b0);
    drive(1'b1, 10'd49, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    // 4: pointer wrap with occupancy held between 2 and 3
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      case (i % 3)
        0:       drive(1'b1, RES_W'($urandom_range(0, 1023)), 1'b0, 1'b0);
        1:       drive(1'b1, RES_W'($urandom_range(0, 1023)), 1'b1, 1'b0);
        default: drive(1'b0, '0, 1'b1, 1'b0);
      endcase
    end

    // 5: hold full and keep pushing until the drop counter saturates
    for (int i = 0; i < 302; i++)
      drive(1'b1, RES_W'($urandom_range(0, 1023)), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);

    // 6: reset mid-stream with a result in flight
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 10'd321, 1'b0, 1'b1);
    drive(1'b1, 10'd123, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
